xor_cipher_engine: RTL
======================

// Module: xor_cipher_engine
// PURPOSE
//   Parametrised multi-mode XOR cipher core, successor to the single-mode chunk encryptor.
//   Latches a MSG_SIZE-bit block and a KEY_SIZE-bit key, then processes one KEY_SIZE-bit chunk per enabled cycle, LSB chunk first.
//   Supports three modes: static key, rolling key (rotated) and chained (CBC-like), each in encrypt or decrypt direction.
//   Sits between the serial message/key loaders and the output shifter; start/done/ack handshake.
// PARAMETERS
//   MSG_SIZE  64  block width in bits; must be a multiple of KEY_SIZE
//   KEY_SIZE   8  key and chunk width in bits; NUM_CHUNKS = MSG_SIZE/KEY_SIZE (>=2)
// PORTS
//   clk                  in   1                      single clock, rising edge
//   rst                  in   1                      synchronous, active-high reset
//   ena                  in   1                      1 = advance, 0 = stall (all state held)
//   iStart               in   1                      start request, sampled in IDLE only
//   iDecrypt             in   1                      0 = encrypt, 1 = decrypt (chained mode only differs)
//   iMode                in   2                      00 static, 01 rolling, 10 chained, 11 = static
//   iMessage             in   MSG_SIZE               input block (plain or cipher)
//   iKey                 in   KEY_SIZE               key
//   iIV                  in   KEY_SIZE               chain seed for mode 10
//   iAck                 in   1                      consumer acknowledge of oDone
//   oBusy                out  1                      1 in PROC
//   oDone                out  1                      1 in DONE; result stable
//   oCiphertext_counter  out  $clog2(NUM_CHUNKS)+1   chunks completed in current block
//   oCiphertext          out  MSG_SIZE               result block
// BEHAVIOUR
//   Reset (rst=1 at edge, any state): state=IDLE; oBusy=0, oDone=0, counter=0, oCiphertext=0; internal regs cleared.
//   ena=0: no state, register or output changes, including in IDLE/DONE; rst overrides ena.
//   FSM IDLE->PROC->DONE->IDLE.
//   IDLE: on edge with ena&iStart: latch iMessage, iKey, iIV, iMode, iDecrypt; counter=0, oCiphertext=0 -> PROC.
//   PROC: each ena edge writes chunk i=counter into oCiphertext[i*KEY_SIZE +: KEY_SIZE], counter+1.
//     Inputs other than rst/ena ignored in PROC (iStart while busy dropped, no queueing).
//     Chunk i of P/C is bits [i*KEY_SIZE +: KEY_SIZE] of the latched message.
//     static : out_i = m_i ^ K.
//     rolling: out_i = m_i ^ rotl(K, i mod KEY_SIZE); kept as key reg rotated left 1 per chunk.
//     chained enc: out_i = m_i ^ K ^ fb; fb = IV for i=0, else out_{i-1}.
//     chained dec: out_i = m_i ^ K ^ fb; fb = IV for i=0, else m_{i-1} (input ciphertext chunk).
//     Encrypt/decrypt identical for static and rolling; dec(enc(x)) = x in all modes.
//   Last chunk edge (counter becomes NUM_CHUNKS): -> DONE, same edge. Latency: start edge N, done visible after edge N+NUM_CHUNKS.
//   DONE: oDone=1, oCiphertext and counter held, counter==NUM_CHUNKS. ena&iAck -> IDLE, oDone=0.
//     iStart in DONE ignored; new start needs IDLE (earliest one cycle after ack).
//     Result stays on oCiphertext in IDLE until next start clears it.
//   Counter never exceeds NUM_CHUNKS; no wrap. Reset mid-PROC abandons block, no oDone pulse.
// TESTING (MSG_SIZE=32, KEY_SIZE=8, msg=0x11223344, K=0xA5)
//   static enc, ena=1: start -> oDone 4 cycles later, oCiphertext=0xB48796E1, counter=4.
//   rolling enc: -> 0x3CB478E1 (keys A5,4B,96,2D); rerun with 0x3CB478E1 -> 0x11223344.
//   chained enc IV=0x00 -> 0x44F077E1; chained dec of 0x44F077E1 -> 0x11223344.
//   ena toggled 1/0 every cycle during PROC -> same result, done after 8 cycles; iStart in PROC/DONE ignored.
//   rst pulsed after 2 chunks -> next cycle IDLE, all outputs 0; fresh start completes normally.
//   oDone held 5 cycles with iAck=0 -> outputs stable; iAck=1 -> IDLE, oDone=0 next edge.

Source files
------------

// File: rtl/xor_cipher_engine.sv
// Multi-mode XOR block cipher core: static, rolling and chained key modes.
// Processes one KEY_SIZE chunk per enabled cycle with a start/done/ack handshake.
module xor_cipher_engine #(
   parameter int MSG_SIZE = 64,
   parameter int KEY_SIZE = 8
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic                                         ena,
   input  logic                                         iStart,
   input  logic                                         iDecrypt,
   input  logic [1:0]                                   iMode,
   input  logic [MSG_SIZE-1:0]                          iMessage,
   input  logic [KEY_SIZE-1:0]                          iKey,
   input  logic [KEY_SIZE-1:0]                          iIV,
   input  logic                                         iAck,
   output logic                                         oBusy,
   output logic                                         oDone,
   output logic [$clog2(MSG_SIZE/KEY_SIZE):0]           oCiphertext_counter,
   output logic [MSG_SIZE-1:0]                          oCiphertext
);

   localparam int NUM_CHUNKS = MSG_SIZE / KEY_SIZE;
   localparam int CW         = $clog2(NUM_CHUNKS) + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PROC,
      S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [MSG_SIZE-1:0]  msg_q, msg_d;
   logic [KEY_SIZE-1:0]  key_q, key_d;
   logic [KEY_SIZE-1:0]  fb_q, fb_d;
   logic [1:0]           mode_q, mode_d;
   logic                 dec_q, dec_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [MSG_SIZE-1:0]  ct_q, ct_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   logic [KEY_SIZE-1:0]  chunk_in;
   logic [KEY_SIZE-1:0]  chunk_out;

   // The latched message shifts right each chunk, so the current chunk is always at the bottom.
   assign chunk_in = msg_q[KEY_SIZE-1:0];

   always_comb begin
      if (mode_q == 2'b10) chunk_out = chunk_in ^ key_q ^ fb_q;
      else                 chunk_out = chunk_in ^ key_q;
   end

   always_comb begin
      state_d = state_q;
      msg_d   = msg_q;
      key_d   = key_q;
      fb_d    = fb_q;
      mode_d  = mode_q;
      dec_d   = dec_q;
      cnt_d   = cnt_q;
      ct_d    = ct_q;
      busy_d  = busy_q;
      done_d  = done_q;
      if (ena) begin
         case (state_q)
            S_IDLE: begin
               if (iStart) begin
                  msg_d   = iMessage;
                  key_d   = iKey;
                  fb_d    = iIV;
                  mode_d  = iMode;
                  dec_d   = iDecrypt;
                  cnt_d   = '0;
                  ct_d    = '0;
                  busy_d  = 1'b1;
                  state_d = S_PROC;
               end
            end
            S_PROC: begin
               for (int unsigned i = 0; i < NUM_CHUNKS; i++) begin
                  if (cnt_q == CW'(i)) ct_d[i*KEY_SIZE +: KEY_SIZE] = chunk_out;
               end
               msg_d = msg_q >> KEY_SIZE;
               if (mode_q == 2'b01) key_d = {key_q[KEY_SIZE-2:0], key_q[KEY_SIZE-1]};
               // Encrypt chains on produced ciphertext, decrypt on the incoming ciphertext chunk.
               fb_d  = dec_q ? chunk_in : chunk_out;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CW'(NUM_CHUNKS - 1)) begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end
            end
            S_DONE: begin
               if (iAck) begin
                  done_d  = 1'b0;
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         msg_q   <= '0;
         key_q   <= '0;
         fb_q    <= '0;
         mode_q  <= '0;
         dec_q   <= 1'b0;
         cnt_q   <= '0;
         ct_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         msg_q   <= msg_d;
         key_q   <= key_d;
         fb_q    <= fb_d;
         mode_q  <= mode_d;
         dec_q   <= dec_d;
         cnt_q   <= cnt_d;
         ct_q    <= ct_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign oBusy               = busy_q;
   assign oDone               = done_q;
   assign oCiphertext_counter = cnt_q;
   assign oCiphertext         = ct_q;

endmodule
